// File: rtl/sumsq_accum.sv
// Purpose: sums N consecutive squares from the squarer into a saturating frame total with a per-frame clamp flag.
// Latency: out_valid rises on the clock edge after the N-th accepted square.
// Backpressure: in_ready drops while a completed frame waits for out_ready; one bubble cycle follows each handshake.
module sumsq_accum #(
    parameter int SQ_W  = 6,
    parameter int N     = 8,
    parameter int ACC_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SQ_W-1:0]   sq_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  sum_out,
    output logic              sat_out
);

    localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
    localparam int WIDE_W = ACC_W + 1;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sat_acc;
    logic [ACC_W-1:0]   r_sum_out;
    logic               r_sat_out;
    logic               r_out_valid;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_last;
    logic [WIDE_W-1:0]  w_sum_wide;
    logic               w_clamp;
    logic [ACC_W-1:0]   w_acc_nx;
    logic               w_out_hs;

    // One extra bit catches the carry out of the accumulator; any carry means clamp to all-ones.
    assign w_sum_wide = {1'b0, r_acc} + WIDE_W'(sq_in);
    assign w_clamp    = w_sum_wide[ACC_W];
    assign w_acc_nx   = w_clamp ? {ACC_W{1'b1}} : w_sum_wide[ACC_W-1:0];
    assign w_last     = (r_cnt == CNT_W'(N - 1));
    assign w_accept   = in_valid && w_in_ready;
    assign w_out_hs   = r_out_valid && out_ready;

    // State register: reset lands in ACC so in_ready is high while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state: clear aborts everything; last accept parks in HOLD until the frame is taken.
    always_comb begin
        w_state_nx = r_state;
        if (clear) begin
            w_state_nx = ST_ACC;
        end else begin
            case (r_state)
                ST_ACC:  if (w_accept && w_last) w_state_nx = ST_HOLD;
                ST_HOLD: if (w_out_hs)           w_state_nx = ST_ACC;
                default:                         w_state_nx = ST_ACC;
            endcase
        end
    end

    // Output decode: input is only taken while accumulating and not being cleared.
    always_comb begin
        w_in_ready = 1'b0;
        if (r_state == ST_ACC && !clear) begin
            w_in_ready = 1'b1;
        end
    end

    // Datapath: accumulate, close the frame on the N-th accept, retire it on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sat_acc   <= 1'b0;
            r_sum_out   <= '0;
            r_sat_out   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (clear) begin
            // sum_out/sat_out deliberately keep their last values on abort.
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sat_acc   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            if (w_last) begin
                r_sum_out   <= w_acc_nx;
                r_sat_out   <= r_sat_acc | w_clamp;
                r_out_valid <= 1'b1;
                r_acc       <= '0;
                r_cnt       <= '0;
                r_sat_acc   <= 1'b0;
            end else begin
                r_acc     <= w_acc_nx;
                r_cnt     <= r_cnt + CNT_W'(1);
                r_sat_acc <= r_sat_acc | w_clamp;
            end
        end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign sum_out   = r_sum_out;
    assign sat_out   = r_sat_out;

endmodule
